// File: rtl/multiply_divide_unit.sv
// Iterative multiply/divide unit that owns the HI/LO register pair.
// MUL/MULU use radix-2 shift-add, and DIV/DIVU use restoring division.
// Each takes DATA_WIDTH+1 cycles from accept to result. MTHI/MTLO write directly.
module multiply_divide_unit #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MDU_OP_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stall,
  input  logic                    flush,
  input  logic [MDU_OP_WIDTH-1:0] op,
  input  logic [DATA_WIDTH-1:0]   rs,
  input  logic [DATA_WIDTH-1:0]   rt,
  output logic [DATA_WIDTH-1:0]   hi,
  output logic [DATA_WIDTH-1:0]   lo,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned W    = DATA_WIDTH;
  localparam int unsigned CntW = $clog2(DATA_WIDTH);

  localparam logic [MDU_OP_WIDTH-1:0] OpMul  = MDU_OP_WIDTH'(1);
  localparam logic [MDU_OP_WIDTH-1:0] OpMulu = MDU_OP_WIDTH'(2);
  localparam logic [MDU_OP_WIDTH-1:0] OpDiv  = MDU_OP_WIDTH'(3);
  localparam logic [MDU_OP_WIDTH-1:0] OpDivu = MDU_OP_WIDTH'(4);
  localparam logic [MDU_OP_WIDTH-1:0] OpMthi = MDU_OP_WIDTH'(5);
  localparam logic [MDU_OP_WIDTH-1:0] OpMtlo = MDU_OP_WIDTH'(6);

  typedef enum logic [1:0] {StIdle, StCalc, StFinish} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  // Multiply: {partial product high, remaining multiplier bits}.
  // Divide: {partial remainder, dividend bits shifting into quotient}.
  logic [2*W-1:0]    acc_q, acc_d;
  logic [W-1:0]      b_q, b_d;          // multiplicand or divisor magnitude
  logic              is_div_q, is_div_d;
  logic              neg_res_q, neg_res_d;  // negate product / quotient
  logic              neg_rem_q, neg_rem_d;  // negate remainder (dividend sign)
  logic              dbz_q, dbz_d;
  logic [W-1:0]      hi_q, hi_d, lo_q, lo_d;
  logic              done_q, done_d;

  logic              is_signed_op, is_arith_op, rs_neg, rt_neg;
  logic [W-1:0]      rs_mag, rt_mag;
  logic [W:0]        mul_sum;
  logic [W:0]        div_tmp;
  logic              div_ge;
  logic [W-1:0]      div_rem;
  logic [2*W-1:0]    fin_prod;
  logic [W-1:0]      fin_quo, fin_rem;

  // Operand preparation, datapath step and FSM next-state
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    b_d       = b_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    is_signed_op = (op == OpMul) || (op == OpDiv);
    is_arith_op  = (op == OpMul) || (op == OpMulu) || (op == OpDiv) || (op == OpDivu);
    rs_neg       = is_signed_op && rs[W-1];
    rt_neg       = is_signed_op && rt[W-1];
    rs_mag       = rs_neg ? -rs : rs;
    rt_mag       = rt_neg ? -rt : rt;

    mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b_q} : '0);
    div_tmp  = {acc_q[2*W-1:W], acc_q[W-1]};
    div_ge   = div_tmp >= {1'b0, b_q};
    // Partial remainder stays below the divisor, so the low W bits suffice.
    div_rem  = div_ge ? (div_tmp[W-1:0] - b_q) : div_tmp[W-1:0];

    fin_prod = neg_res_q ? -acc_q : acc_q;
    fin_quo  = neg_res_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    fin_rem  = neg_rem_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start && !stall) begin
            if (op == OpMthi) begin
              hi_d = rs;
            end else if (op == OpMtlo) begin
              lo_d = rs;
            end else if (is_arith_op) begin
              is_div_d  = (op == OpDiv) || (op == OpDivu);
              // Multiply: rt shifts out of acc, rs is added.
              // Divide: rs is the dividend, rt the divisor.
              acc_d     = is_div_d ? {{W{1'b0}}, rs_mag} : {{W{1'b0}}, rt_mag};
              b_d       = is_div_d ? rt_mag : rs_mag;
              neg_res_d = rs_neg ^ rt_neg;
              neg_rem_d = rs_neg;
              dbz_d     = is_div_d && (rt == '0);
              cnt_d     = CntW'(W - 1);
              state_d   = StCalc;
            end
          end
        end
        StCalc: begin
          if (is_div_q) begin
            acc_d = {div_rem, acc_q[W-2:0], div_ge};
          end else begin
            acc_d = {mul_sum, acc_q[W-1:1]};
          end
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_d = StFinish;
          end
        end
        StFinish: begin
          if (is_div_q) begin
            // With a zero divisor, the remainder path reproduces rs.
            hi_d = fin_rem;
            lo_d = dbz_q ? '1 : fin_quo;
          end else begin
            {hi_d, lo_d} = fin_prod;
          end
          done_d  = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and architectural register update with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != StIdle);
  assign done = done_q;

endmodule

// File: tb/tb_multiply_divide_unit.sv
// Self-checking bench for multiply_divide_unit (DATA_WIDTH = 32).
// An arithmetic reference model is compared every cycle.
// Directed vectors carry literal expected results.
module tb_multiply_divide_unit;

  logic        clk, rst, start, stall, flush;
  logic [2:0]  op;
  logic [31:0] rs, rt;
  logic [31:0] hi, lo;
  logic        busy, done;

  int vecs = 0;
  int errs = 0;

  multiply_divide_unit #(
    .DATA_WIDTH  (32),
    .MDU_OP_WIDTH(3)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .stall(stall),
    .flush(flush),
    .op   (op),
    .rs   (rs),
    .rt   (rt),
    .hi   (hi),
    .lo   (lo),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: results come from plain arithmetic.
  // Only the latency is modelled as a countdown.
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  int          m_rem;
  logic        m_done;
  logic        m_valid = 1'b0;

  function automatic void calc(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] h, output logic [31:0] l);
    longint      sp;
    logic [63:0] up;
    h = '0;
    l = '0;
    case (o)
      3'd1: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        {h, l} = sp;
      end
      3'd2: begin
        up = {32'b0, a} * {32'b0, b};
        {h, l} = up;
      end
      3'd3: begin
        if (b == 0) begin
          h = a;
          l = '1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          h = 32'h0;
          l = 32'h8000_0000;
        end else begin
          l = $signed(a) / $signed(b);
          h = $signed(a) % $signed(b);
        end
      end
      3'd4: begin
        if (b == 0) begin
          h = a;
          l = '1;
        end else begin
          l = a / b;
          h = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  always @(posedge clk) begin
    m_done = 1'b0;
    if (rst) begin
      m_hi  = '0;
      m_lo  = '0;
      m_rem = 0;
    end else if (flush) begin
      m_rem = 0;
    end else if (m_rem > 0) begin
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        m_hi   = p_hi;
        m_lo   = p_lo;
        m_done = 1'b1;
      end
    end else if (start && !stall) begin
      case (op)
        3'd1, 3'd2, 3'd3, 3'd4: begin
          calc(op, rs, rt, p_hi, p_lo);
          m_rem = 33;
        end
        3'd5: m_hi = rs;
        3'd6: m_lo = rs;
        default: ;
      endcase
    end
    m_valid = 1'b1;
  end

  // Cycle-by-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (m_valid) begin
      vecs++;
      if ({hi, lo, busy, done} !== {m_hi, m_lo, (m_rem != 0), m_done}) begin
        errs++;
        $display("FAIL model t=%0t: got hi=%h lo=%h busy=%b done=%b, want hi=%h lo=%h busy=%b done=%b",
                 $time, hi, lo, busy, done, m_hi, m_lo, (m_rem != 0), m_done);
      end
    end
  end

  // Length of the most recent busy run
  int busy_len = 0;
  int last_busy_len = 0;
  always @(negedge clk) begin
    if (busy) busy_len++;
    else if (busy_len != 0) begin
      last_busy_len = busy_len;
      busy_len = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start = 1'b1; op = o; rs = a; rt = b;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 60);
    if (!done) begin
      vecs++;
      errs++;
      $display("FAIL %s: done timeout, got done=%b, want 1", name, done);
    end
  endtask

  task automatic run(input string name, input logic [2:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    issue(o, a, b);
    wait_done(name);
    check({name, ".hi"}, hi, eh);
    check({name, ".lo"}, lo, el);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int done_seen;

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0; flush = 1'b0; op = 3'd0; rs = '0; rt = '0;
    cycles(3);
    @(negedge clk);
    check("rst.hi", hi, 32'h0);
    check("rst.lo", lo, 32'h0);
    check("rst.busy", {31'b0, busy}, 32'h0);
    check("rst.done", {31'b0, done}, 32'h0);
    rst = 1'b0;

    run("mul_neg3x5", 3'd1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    @(negedge clk);
    check("mul.busy_len", last_busy_len, 32'd33);
    run("mulu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    issue(3'd6, 32'h1234_5678, 32'h0);
    @(negedge clk);
    check("mtlo.lo", lo, 32'h1234_5678);
    check("mtlo.busy", {31'b0, busy}, 32'h0);
    run("mul_minxmin", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
    run("div_neg7_2", 3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("divu_7_2", 3'd4, 32'd7, 32'd2, 32'd1, 32'd3);
    run("divu_by0", 3'd4, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
    run("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run("div_neg_by0", 3'd3, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run("div_7_neg2", 3'd3, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);

    // Flush mid-multiply leaves HI/LO untouched and suppresses done
    issue(3'd5, 32'hAAAA_5555, 32'h0);
    issue(3'd6, 32'hAAAA_5555, 32'h0);
    issue(3'd1, 32'd3, 32'd4);
    cycles(8);
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
    @(negedge clk);
    check("flush.busy", {31'b0, busy}, 32'h0);
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("flush.done_seen", done_seen, 32'd0);
    check("flush.hi", hi, 32'hAAAA_5555);
    check("flush.lo", lo, 32'hAAAA_5555);

    // start together with flush is ignored
    @(posedge clk); #1;
    start = 1'b1; op = 3'd1; rs = 32'd2; rt = 32'd2; flush = 1'b1;
    cycles(1);
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_start.busy", {31'b0, busy}, 32'h0);

    // Reset mid-multiply clears everything
    issue(3'd1, 32'd9, 32'd9);
    cycles(8);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    @(negedge clk);
    check("rstmid.hi", hi, 32'h0);
    check("rstmid.lo", lo, 32'h0);
    check("rstmid.busy", {31'b0, busy}, 32'h0);

    // Stall blocks acceptance
    @(posedge clk); #1;
    stall = 1'b1; start = 1'b1; op = 3'd5; rs = 32'hDEAD_BEEF;
    cycles(1);
    op = 3'd1;
    cycles(1);
    start = 1'b0; stall = 1'b0;
    @(negedge clk);
    check("stall.hi", hi, 32'h0);
    check("stall.busy", {31'b0, busy}, 32'h0);

    // A start while busy is ignored, and a back-to-back start after done is accepted
    issue(3'd2, 32'd7, 32'd6);
    cycles(5);
    start = 1'b1; op = 3'd4; rs = 32'd50; rt = 32'd3;
    cycles(1);
    start = 1'b0;
    wait_done("busy_start");
    check("busy_start.hi", hi, 32'd0);
    check("busy_start.lo", lo, 32'd42);
    start = 1'b1; op = 3'd4; rs = 32'd100; rt = 32'd7;
    cycles(1);
    start = 1'b0; op = 3'd0;
    @(negedge clk);
    check("b2b.busy", {31'b0, busy}, 32'h1);
    wait_done("b2b");
    check("b2b.hi", hi, 32'd2);
    check("b2b.lo", lo, 32'd14);

    cycles(3);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
